serial_port_uart: RTL

Peripheral end of the processor's byte-wide serial port: the block that answers the processor-side `serial_*` handshake. It accepts bytes written by the processor into a TX FIFO and shifts them out as 8N1 UART frames. It also deserializes incoming UART frames into a one-byte holding register that the processor reads. It sits at the top level between the processor core's serial port pins and the board UART pins.

---
 rtl/serial_port_uart.sv | 368 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_port_uart.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_port_uart
// Description : Peripheral end of the processor's byte-wide serial port.
//               Bytes written by the processor are queued in a TX FIFO and
//               shifted out as 8N1 UART frames. Incoming 8N1 frames are
//               deserialized into a one-byte holding register that the
//               processor reads with a consume strobe.
//
// Parameters  : CLKS_PER_BIT   clock cycles per UART bit (>= 4)
//               TX_FIFO_DEPTH  TX FIFO entries (power of two, >= 2)
//
// Ports       : clock            single clock for all logic
//               reset            asynchronous, active-high reset
//               tx_data_in       byte from processor
//               tx_wren_in       write strobe (one byte per cycle high)
//               tx_ready_out     TX FIFO not full
//               rx_data_out      holding-register byte
//               rx_valid_out     holding register full
//               rx_rden_in       consume strobe
//               rx_overrun_out   sticky: a received byte was dropped
//               rx_frame_err_out one-cycle pulse on a stop bit sampled as 0
//               uart_rxd_in      serial input line (idle high)
//               uart_txd_out     serial output line (idle high, registered)
//
// Build macro : SERIAL_LOOPBACK_EN
//               Defined   - RX is fed from the internal TX line and
//                           uart_txd_out is held at 1.
//               Undefined - normal external operation.
//
// Revision    : 1.0  initial release
// ============================================================================
module serial_port_uart #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data_in,
    input  logic       tx_wren_in,
    output logic       tx_ready_out,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    input  logic       rx_rden_in,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out,
    input  logic       uart_rxd_in,
    output logic       uart_txd_out
);

    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_bit  = CNT_W'(CLKS_PER_BIT / 2);
    // The falling edge is only seen after the two synchronizer stages, so
    // the start-bit count resumes at 2; the sample then lands on the
    // line value at mid-bit.
    localparam logic [CNT_W-1:0] c_rx_cnt_init = CNT_W'(2);
    localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);
    localparam logic [PTR_W:0]   c_count_one = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   c_fifo_full = (PTR_W+1)'(TX_FIFO_DEPTH);
    localparam logic [2:0]       c_idx_last  = 3'd7;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem_q [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W:0]   count_d;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_empty;
    logic [7:0]       w_fifo_head;

    assign tx_ready_out = (count_q != c_fifo_full);
    assign w_fifo_empty = (count_q == '0);
    assign w_push       = tx_wren_in && tx_ready_out;
    assign w_fifo_head  = fifo_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_count_one;
            2'b01:   count_d = count_q - c_count_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clock) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= tx_data_in;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_idx_q;
    logic [7:0]       tx_shift_q;
    logic             tx_line_q;
    logic             w_tx_bit_end;

    assign w_tx_bit_end = (tx_cnt_q == c_bit_last);

    // A byte leaves the FIFO when the transmitter is idle, or at the very
    // end of a stop bit so consecutive frames follow with no idle gap.
    assign w_pop = !w_fifo_empty &&
                   ((tx_state_q == TX_IDLE) ||
                    ((tx_state_q == TX_STOP) && w_tx_bit_end));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= '0;
                    if (!w_fifo_empty) begin
                        tx_shift_q <= w_fifo_head;
                        tx_line_q  <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + c_cnt_one;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == c_idx_last) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            // Bit 0 of the shifter is always the bit on the line.
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_line_q  <= tx_shift_q[1];
                            tx_idx_q   <= tx_idx_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + c_cnt_one;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (!w_fifo_empty) begin
                            tx_shift_q <= w_fifo_head;
                            tx_line_q  <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + c_cnt_one;
                    end
                end
                default: begin
                    tx_cnt_q   <= '0;
                    tx_line_q  <= 1'b1;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line routing
    // ------------------------------------------------------------------
    logic w_rx_line;

`ifdef SERIAL_LOOPBACK_EN
    logic w_unused_rxd;
    assign w_unused_rxd = uart_rxd_in;
    assign w_rx_line    = tx_line_q;
    assign uart_txd_out = 1'b1;
`else
    assign w_rx_line    = uart_rxd_in;
    assign uart_txd_out = tx_line_q;
`endif

    // ------------------------------------------------------------------
    // RX synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_sync1_q;
    logic rx_sync2_q;
    logic rx_prev_q;
    logic w_rx_fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= w_rx_line;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    assign w_rx_fall = rx_prev_q && !rx_sync2_q;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_idx_q;
    logic [7:0]       rx_shift_q;
    logic             rx_deliver_q;
    logic             rx_frame_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_idx_q       <= '0;
            rx_shift_q     <= '0;
            rx_deliver_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_deliver_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        rx_cnt_q   <= c_rx_cnt_init;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == c_half_bit) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= '0;
                        // A line back high at mid-start-bit was only a glitch.
                        rx_state_q <= rx_sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + c_cnt_one;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == c_bit_last) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
                        if (rx_idx_q == c_idx_last) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + c_cnt_one;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == c_bit_last) begin
                        rx_cnt_q       <= '0;
                        rx_state_q     <= RX_IDLE;
                        rx_deliver_q   <= rx_sync2_q;
                        rx_frame_err_q <= !rx_sync2_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + c_cnt_one;
                    end
                end
                default: begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    logic [7:0] hold_data_q;
    logic       hold_valid_q;
    logic       hold_overrun_q;
    logic       w_read;

    // A consume strobe only counts while a byte is actually held.
    assign w_read = rx_rden_in && hold_valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_data_q    <= '0;
            hold_valid_q   <= 1'b0;
            hold_overrun_q <= 1'b0;
        end else begin
            if (rx_deliver_q) begin
                if (hold_valid_q && !w_read) begin
                    // Register still owned by the processor: keep old byte.
                    hold_overrun_q <= 1'b1;
                end else begin
                    hold_data_q  <= rx_shift_q;
                    hold_valid_q <= 1'b1;
                    if (w_read) begin
                        hold_overrun_q <= 1'b0;
                    end
                end
            end else if (w_read) begin
                hold_valid_q   <= 1'b0;
                hold_overrun_q <= 1'b0;
            end
        end
    end

    assign rx_data_out      = hold_data_q;
    assign rx_valid_out     = hold_valid_q;
    assign rx_overrun_out   = hold_overrun_q;
    assign rx_frame_err_out = rx_frame_err_q;

endmodule
`default_nettype wire
